// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control sequencer and datapath.
// Contents:
//   state_t      - FSM state encoding
//   OPC_*        - major opcodes handled by the sequencer
//   ALUOP_*      - 2-bit alu_op encodings fed to alu_control
//   SRC_A_*, SRC_B_*, PC_SRC_*, IORD_*, WB_* - mux select encodings shared with the datapath
//   ctrl_word_t  - bundle of every control strobe/select driven by the sequencer
//   decode_next  - opcode to post-DECODE state mapping
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EX_R    = 4'd2,
      S_EX_ADDR = 4'd3,
      S_EX_BR   = 4'd4,
      S_MEM_LD  = 4'd5,
      S_MEM_ST  = 4'd6,
      S_WB_R    = 4'd7,
      S_WB_LD   = 4'd8,
      S_HALT    = 4'd9
   } state_t;

   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_LD = 7'b0000011;
   localparam logic [6:0] OPC_ST = 7'b0100011;
   localparam logic [6:0] OPC_BR = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_RS1   = 2'b01;
   localparam logic [1:0] SRC_A_OLDPC = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   localparam logic PC_SRC_ALU    = 1'b0;
   localparam logic PC_SRC_ALUOUT = 1'b1;
   localparam logic IORD_PC       = 1'b0;
   localparam logic IORD_ALUOUT   = 1'b1;
   localparam logic WB_ALUOUT     = 1'b0;
   localparam logic WB_MDR        = 1'b1;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_br;
      logic       pc_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_word_t;

   // Loads and stores share the address-calculation state; anything unknown halts.
   function automatic state_t decode_next(input logic [6:0] opc);
      state_t nxt;
      case (opc)
         OPC_R:          nxt = S_EX_R;
         OPC_LD, OPC_ST: nxt = S_EX_ADDR;
         OPC_BR:         nxt = S_EX_BR;
         default:        nxt = S_HALT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Pure combinational state -> control-word decoder for the multi-cycle sequencer.
// Ports:
//   state     in   current FSM state
//   mem_ready in   memory handshake; only qualifies ir_write/pc_write in FETCH
//   ctrl      out  full control word (all fields 0 unless the state sets them)
module multicycle_ctrl_outdec
   import riscv_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   output ctrl_word_t ctrl
);

   // Moore decode of the control word; every field defaults to 0 (alu_op = add).
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.iord      = IORD_PC;
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_src    = PC_SRC_ALU;
            // IR and PC only latch on the cycle the fetch completes.
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRC_A_OLDPC;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_EX_R: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_WB_R: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = WB_ALUOUT;
         end
         S_EX_ADDR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_LD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = IORD_ALUOUT;
         end
         S_WB_LD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = WB_MDR;
         end
         S_MEM_ST: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = IORD_ALUOUT;
         end
         S_EX_BR: begin
            // Datapath ANDs pc_write_br with zero, so the branch is taken iff rs1 == rs2.
            ctrl.alu_src_a   = SRC_A_RS1;
            ctrl.alu_src_b   = SRC_B_RS2;
            ctrl.alu_op      = ALUOP_SUB;
            ctrl.pc_write_br = 1'b1;
            ctrl.pc_src      = PC_SRC_ALUOUT;
         end
         S_HALT:  ctrl = '0;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control sequencer for the multi-cycle RV32 datapath (R-type, LW, SW, BEQ).
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   instr               instruction register (opcode used from DECODE on)
//   zero                ALU zero flag (consumed by the datapath via pc_write_br)
//   mem_ready           current memory request completes this cycle
//   mem_read/mem_write  memory request strobes
//   iord, ir_write, pc_write, pc_write_br, pc_src, alu_src_a, alu_src_b, alu_op,
//   reg_write, mem_to_reg  datapath controls
//   illegal             sticky illegal-opcode flag
//   retired             retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_ctrl_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_br,
   output logic             pc_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t           state_r;
   state_t           next_state_s;
   logic             illegal_r;
   logic [CNT_W-1:0] retired_r;
   logic             retire_s;
   ctrl_word_t       dec_s;
   ctrl_word_t       ctrl_s;

   // Only the opcode steers the sequencer; zero is applied by the datapath.
   logic unused_s;
   assign unused_s = ^{instr[31:7], zero};

   multicycle_ctrl_outdec u_outdec (
      .state     (state_r),
      .mem_ready (mem_ready),
      .ctrl      (dec_s)
   );

   // Force every strobe low while reset is held so an in-flight access is aborted.
   always_comb begin
      if (!rst_n) begin
         ctrl_s = '0;
      end else begin
         ctrl_s = dec_s;
      end
   end

   assign mem_read    = ctrl_s.mem_read;
   assign mem_write   = ctrl_s.mem_write;
   assign iord        = ctrl_s.iord;
   assign ir_write    = ctrl_s.ir_write;
   assign pc_write    = ctrl_s.pc_write;
   assign pc_write_br = ctrl_s.pc_write_br;
   assign pc_src      = ctrl_s.pc_src;
   assign alu_src_a   = ctrl_s.alu_src_a;
   assign alu_src_b   = ctrl_s.alu_src_b;
   assign alu_op      = ctrl_s.alu_op;
   assign reg_write   = ctrl_s.reg_write;
   assign mem_to_reg  = ctrl_s.mem_to_reg;
   assign illegal     = illegal_r;
   assign retired     = retired_r;

   // Next-state logic and the final-cycle-of-instruction (retire) indicator.
   always_comb begin
      next_state_s = S_FETCH;
      retire_s     = 1'b0;
      case (state_r)
         S_FETCH:   next_state_s = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:  next_state_s = decode_next(instr[6:0]);
         S_EX_R:    next_state_s = S_WB_R;
         S_WB_R: begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
         end
         // Opcode bit 5 separates store (0100011) from load (0000011).
         S_EX_ADDR: next_state_s = instr[5] ? S_MEM_ST : S_MEM_LD;
         S_MEM_LD:  next_state_s = mem_ready ? S_WB_LD : S_MEM_LD;
         S_WB_LD: begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
         end
         S_MEM_ST: begin
            next_state_s = mem_ready ? S_FETCH : S_MEM_ST;
            retire_s     = mem_ready;
         end
         S_EX_BR: begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
         end
         S_HALT:    next_state_s = S_HALT;
         default:   next_state_s = S_FETCH;
      endcase
   end

   // State register, sticky illegal flag and retired counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= S_FETCH;
         illegal_r <= 1'b0;
         retired_r <= '0;
      end else begin
         state_r <= next_state_s;
         if (next_state_s == S_HALT) begin
            illegal_r <= 1'b1;
         end else begin
            illegal_r <= illegal_r;
         end
         if (retire_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            retired_r <= retired_r;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm.
module tb_multicycle_ctrl_fsm;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_br, pc_src;
   logic [1:0]  alu_src_a, alu_src_b, alu_op;
   logic        reg_write, mem_to_reg, illegal;
   logic [31:0] retired;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_ret = 32'd0;

   multicycle_ctrl_fsm #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_br(pc_write_br), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1; instr = 32'd0; zero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read cyc=%0d got=%b want=0", i, mem_read); end
         total++; if (ir_write !== 1'b0) begin bad++; $display("FAIL reset_ir_write cyc=%0d got=%b want=0", i, ir_write); end
      end
      total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
      rst_n = 1'b1; mem_ready = 1'b0;
      #1;
      total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL release_mem_read got=%b want=1", mem_read); end
      total++; if (iord !== 1'b0 || alu_src_b !== 2'b01 || ir_write !== 1'b0) begin
         bad++; $display("FAIL release_fetch_sel got iord=%b b=%b irw=%b want 0/01/0", iord, alu_src_b, ir_write); end
   endtask

   task automatic test_add();
      instr = 32'h002081B3; mem_ready = 1'b1;
      #1;
      total++; if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 1'b0) begin
         bad++; $display("FAIL add_fetch got irw=%b pcw=%b src=%b want 1/1/0", ir_write, pc_write, pc_src); end
      tick(); // DECODE
      total++; if (alu_src_a !== 2'b10 || alu_src_b !== 2'b10 || alu_op !== 2'b00 || reg_write !== 1'b0) begin
         bad++; $display("FAIL add_decode got a=%b b=%b op=%b rw=%b want 10/10/00/0", alu_src_a, alu_src_b, alu_op, reg_write); end
      tick(); // EX_R
      total++; if (alu_op !== 2'b10 || alu_src_a !== 2'b01 || alu_src_b !== 2'b00 || reg_write !== 1'b0) begin
         bad++; $display("FAIL add_exr got op=%b a=%b b=%b rw=%b want 10/01/00/0", alu_op, alu_src_a, alu_src_b, reg_write); end
      tick(); // WB_R
      total++; if (reg_write !== 1'b1 || mem_to_reg !== 1'b0 || alu_op !== 2'b00 || mem_read !== 1'b0) begin
         bad++; $display("FAIL add_wbr got rw=%b m2r=%b op=%b mr=%b want 1/0/00/0", reg_write, mem_to_reg, alu_op, mem_read); end
      tick(); // FETCH
      exp_ret = exp_ret + 32'd1;
      total++; if (retired !== exp_ret || mem_read !== 1'b1 || reg_write !== 1'b0) begin
         bad++; $display("FAIL add_done got ret=%0d mr=%b rw=%b want %0d/1/0", retired, mem_read, reg_write, exp_ret); end
   endtask

   task automatic test_lw();
      instr = 32'h0000A183; mem_ready = 1'b1;
      #1;
      tick(); // DECODE
      tick(); // EX_ADDR
      total++; if (alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || alu_op !== 2'b00 || mem_read !== 1'b0) begin
         bad++; $display("FAIL lw_exaddr got a=%b b=%b op=%b mr=%b want 01/10/00/0", alu_src_a, alu_src_b, alu_op, mem_read); end
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); // MEM_LD, ready on the 4th cycle
         mem_ready = (i == 3);
         total++; if (mem_read !== 1'b1 || iord !== 1'b1 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
            bad++; $display("FAIL lw_memld cyc=%0d got mr=%b iord=%b mw=%b rw=%b want 1/1/0/0", i, mem_read, iord, mem_write, reg_write); end
      end
      tick(); // WB_LD
      total++; if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || mem_read !== 1'b0) begin
         bad++; $display("FAIL lw_wbld got rw=%b m2r=%b mr=%b want 1/1/0", reg_write, mem_to_reg, mem_read); end
      tick(); // FETCH, 8 cycles after start
      exp_ret = exp_ret + 32'd1;
      total++; if (retired !== exp_ret || mem_read !== 1'b1 || iord !== 1'b0) begin
         bad++; $display("FAIL lw_done got ret=%0d mr=%b iord=%b want %0d/1/0", retired, mem_read, iord, exp_ret); end
   endtask

   task automatic test_beq();
      instr = 32'h00208463; mem_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         zero = (k == 0);
         #1;
         tick(); // DECODE
         tick(); // EX_BR
         total++; if (pc_write_br !== 1'b1 || alu_op !== 2'b01 || pc_src !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b00) begin
            bad++; $display("FAIL beq_exbr k=%0d got pwb=%b op=%b src=%b a=%b b=%b want 1/01/1/01/00", k, pc_write_br, alu_op, pc_src, alu_src_a, alu_src_b); end
         tick(); // FETCH after 3 cycles
         exp_ret = exp_ret + 32'd1;
         total++; if (mem_read !== 1'b1 || pc_write_br !== 1'b0 || retired !== exp_ret) begin
            bad++; $display("FAIL beq_done k=%0d got mr=%b pwb=%b ret=%0d want 1/0/%0d", k, mem_read, pc_write_br, retired, exp_ret); end
      end
   endtask

   task automatic test_illegal();
      instr = 32'h0000007F; mem_ready = 1'b1;
      #1;
      tick(); // DECODE
      tick(); // HALT
      for (int i = 0; i < 10; i++) begin
         total++; if (illegal !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0 || ir_write !== 1'b0) begin
            bad++; $display("FAIL halt cyc=%0d got ill=%b mr=%b mw=%b rw=%b irw=%b want 1/0/0/0/0", i, illegal, mem_read, mem_write, reg_write, ir_write); end
         tick();
      end
      total++; if (retired !== exp_ret) begin bad++; $display("FAIL halt_retired got=%0d want=%0d", retired, exp_ret); end
      rst_n = 1'b0;
      tick();
      exp_ret = 32'd0;
      total++; if (illegal !== 1'b0 || retired !== exp_ret || mem_read !== 1'b0) begin
         bad++; $display("FAIL halt_reset got ill=%b ret=%0d mr=%b want 0/0/0", illegal, retired, mem_read); end
      rst_n = 1'b1; mem_ready = 1'b0;
      #1;
      tick(); // still FETCH while waiting
      total++; if (mem_read !== 1'b1 || iord !== 1'b0 || alu_src_b !== 2'b01 || ir_write !== 1'b0) begin
         bad++; $display("FAIL halt_restart got mr=%b iord=%b b=%b irw=%b want 1/0/01/0", mem_read, iord, alu_src_b, ir_write); end
   endtask

   task automatic test_store_abort();
      instr = 32'h0020A023; mem_ready = 1'b1;
      #1;
      tick(); // DECODE
      tick(); // EX_ADDR
      tick(); // MEM_ST, ready now
      total++; if (mem_write !== 1'b1 || iord !== 1'b1 || mem_read !== 1'b0) begin
         bad++; $display("FAIL sw_memst got mw=%b iord=%b mr=%b want 1/1/0", mem_write, iord, mem_read); end
      tick(); // FETCH, 4 cycles
      exp_ret = exp_ret + 32'd1;
      total++; if (retired !== exp_ret || mem_read !== 1'b1) begin
         bad++; $display("FAIL sw_done got ret=%0d mr=%b want %0d/1", retired, mem_read, exp_ret); end
      tick(); // DECODE
      tick(); // EX_ADDR
      mem_ready = 1'b0;
      tick(); // MEM_ST waiting
      tick(); // MEM_ST waiting
      total++; if (mem_write !== 1'b1 || retired !== exp_ret) begin
         bad++; $display("FAIL sw_wait got mw=%b ret=%0d want 1/%0d", mem_write, retired, exp_ret); end
      rst_n = 1'b0; mem_ready = 1'b1;
      #1;
      total++; if (mem_write !== 1'b0 || iord !== 1'b0) begin
         bad++; $display("FAIL sw_abort got mw=%b iord=%b want 0/0", mem_write, iord); end
      tick();
      exp_ret = 32'd0;
      total++; if (retired !== exp_ret || mem_write !== 1'b0) begin
         bad++; $display("FAIL sw_abort_ret got ret=%0d mw=%b want 0/0", retired, mem_write); end
      rst_n = 1'b1; mem_ready = 1'b0;
      #1;
      total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || iord !== 1'b0) begin
         bad++; $display("FAIL sw_refetch got mr=%b mw=%b iord=%b want 1/0/0", mem_read, mem_write, iord); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_beq();
      test_illegal();
      test_store_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
